// File: rtl/qmfir_run_ctrl.sv
// Run sequencer for the QM-FIR datapath: frequency reload, paced input feed, output drain/steering.
// Optional drain timeout enabled by defining QMFIR_RUN_TIMEOUT_EN.
module qmfir_run_ctrl #(
  parameter int IADDR_W  = 12,
  parameter int OADDR_W  = 7,
  parameter int GAP      = 0,
  parameter int DRAIN_TO = 1024
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [IADDR_W-1:0] icnt_i,
  input  logic [OADDR_W:0]   ocnt_i,
  input  logic               freq_ld_i,
  input  logic [6:0]         freq_in_i,
  input  logic               fir_valid_i,
  output logic [IADDR_W-1:0] rd_addr_o,
  output logic               in_valid_o,
  output logic               new_freq_o,
  output logic [6:0]         freq_o,
  output logic               wr_en_o,
  output logic [OADDR_W-1:0] wr_addr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic               tmo_o,
  output logic [2:0]         state_o
);

  localparam int GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int OCNT_W = OADDR_W + 1;

  if (GAP < 0 || DRAIN_TO < 1) begin : g_bad_param
    $error("qmfir_run_ctrl: GAP must be >= 0 and DRAIN_TO >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_FREQ, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IADDR_W-1:0]  icnt_q, icnt_d, rd_addr_q, rd_addr_d;
  logic [OCNT_W-1:0]   ocnt_q, ocnt_d, out_cnt_q, out_cnt_d;
  logic [OADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [6:0]          freq_q, freq_d, pend_code_q, pend_code_d;
  logic                pend_q, pend_d, in_valid_q, in_valid_d;
  logic                ovf_q, ovf_d, tmo_q, tmo_d, wr_en;

`ifdef QMFIR_RUN_TIMEOUT_EN
  localparam int DT_W = $clog2(DRAIN_TO + 1);
  logic [DT_W-1:0] drain_cnt_q, drain_cnt_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) drain_cnt_q <= '0;
    else        drain_cnt_q <= drain_cnt_d;
  end
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      icnt_q      <= '0;
      ocnt_q      <= '0;
      rd_addr_q   <= '0;
      out_cnt_q   <= '0;
      wr_addr_q   <= '0;
      gap_q       <= '0;
      freq_q      <= '0;
      pend_code_q <= '0;
      pend_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      icnt_q      <= icnt_d;
      ocnt_q      <= ocnt_d;
      rd_addr_q   <= rd_addr_d;
      out_cnt_q   <= out_cnt_d;
      wr_addr_q   <= wr_addr_d;
      gap_q       <= gap_d;
      freq_q      <= freq_d;
      pend_code_q <= pend_code_d;
      pend_q      <= pend_d;
      in_valid_q  <= in_valid_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    ocnt_d      = ocnt_q;
    rd_addr_d   = rd_addr_q;
    out_cnt_d   = out_cnt_q;
    wr_addr_d   = wr_addr_q;
    gap_d       = gap_q;
    freq_d      = freq_q;
    pend_code_d = pend_code_q;
    pend_d      = pend_q;
    in_valid_d  = 1'b0;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
`ifdef QMFIR_RUN_TIMEOUT_EN
    drain_cnt_d = drain_cnt_q;
`endif

    if (freq_ld_i) begin
      pend_d      = 1'b1;
      pend_code_d = freq_in_i;
    end

    // Output steering is live only while a run is feeding or draining.
    wr_en = fir_valid_i && !abort_i && (state_q == S_FEED || state_q == S_DRAIN);
    if (wr_en) begin
      wr_addr_d = wr_addr_q + OADDR_W'(1);
      if (out_cnt_q != '1) out_cnt_d = out_cnt_q + OCNT_W'(1);
      if (&wr_addr_q) ovf_d = 1'b1;
    end

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && icnt_i != '0) begin
            icnt_d    = icnt_i;
            ocnt_d    = ocnt_i;
            rd_addr_d = '0;
            wr_addr_d = '0;
            out_cnt_d = '0;
            gap_d     = '0;
            ovf_d     = 1'b0;
            tmo_d     = 1'b0;
            if (pend_q || freq_ld_i) begin
              state_d = S_FREQ;
              freq_d  = freq_ld_i ? freq_in_i : pend_code_q;
            end else begin
              state_d = S_FEED;
            end
          end
        end
        S_FREQ: begin
          if (!freq_ld_i) pend_d = 1'b0;
          state_d = S_FEED;
        end
        S_FEED: begin
          if (gap_q == '0) begin
            in_valid_d = 1'b1;
            rd_addr_d  = rd_addr_q + IADDR_W'(1);
            gap_d      = GAP_W'(GAP);
            if (rd_addr_q == icnt_q - IADDR_W'(1)) begin
              state_d = S_DRAIN;
`ifdef QMFIR_RUN_TIMEOUT_EN
              drain_cnt_d = '0;
`endif
            end
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        S_DRAIN: begin
          if (out_cnt_q >= ocnt_q) begin
            state_d = S_DONE;
          end
`ifdef QMFIR_RUN_TIMEOUT_EN
          else if (drain_cnt_q == DT_W'(DRAIN_TO - 1)) begin
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + DT_W'(1);
          end
`endif
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd_addr_o  = rd_addr_q;
  assign in_valid_o = in_valid_q;
  assign new_freq_o = (state_q == S_FREQ);
  assign freq_o     = freq_q;
  assign wr_en_o    = wr_en;
  assign wr_addr_o  = wr_addr_q;
  assign busy_o     = (state_q == S_FREQ) || (state_q == S_FEED) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign ovf_o      = ovf_q;
  assign tmo_o      = tmo_q;
  assign state_o    = state_q;

endmodule

// File: doc/qmfir_run_ctrl.md
# qmfir_run_ctrl

Run sequencer for the QM-FIR datapath. It sits between the UART-programmed control registers and the filter core. On a start request it optionally pulses a frequency reload into the filter, then streams a programmed number of 32-bit words out of the input sample BRAM into the filter's input-valid port at a programmed rate. It then waits for the expected number of filter outputs, steering each one into the output BRAMs with a wrapping write pointer, and reports busy, done, overflow and timeout status.

## Interface
- IADDR_W, 12, input BRAM address width (word count limit 2^IADDR_W-1)
- OADDR_W, 7, output BRAM address width
- GAP, 0, idle cycles inserted between consecutive input reads (0 = one word per cycle)
- DRAIN_TO, 1024, drain timeout in cycles (used only with QMFIR_RUN_TIMEOUT_EN)

- clk  in  1  system clock, all logic on rising edge
- arst  in  1  asynchronous reset, active-high
- start  in  1  run request, sampled in IDLE only
- abort  in  1  terminate run, any state
- icnt  in  IADDR_W  input words to feed; sampled on accepted start
- ocnt  in  OADDR_W+1  outputs expected; sampled on accepted start
- freq_ld  in  1  latch freq_in as pending frequency
- freq_in  in  7  frequency code
- fir_valid  in  1  filter DataValid
- rd_addr  out  IADDR_W  input BRAM port-B address (registered)
- in_valid  out  1  filter InputValid, aligned with BRAM doutb
- new_freq  out  1  one-cycle frequency reload strobe to filter
- freq  out  7  frequency code to filter (registered)
- wr_en  out  1  output BRAM write enable, = fir_valid while in FEED/DRAIN
- wr_addr  out  OADDR_W  output BRAM write pointer
- busy  out  1  high in FREQ/FEED/DRAIN
- done  out  1  one-cycle pulse on run completion
- ovf  out  1  sticky: write pointer wrapped during run
- tmo  out  1  sticky: run ended by drain timeout

## Operation
- States: IDLE, FREQ, FEED, DRAIN, DONE.
- IDLE: start=1 with icnt!=0 and abort=0 → capture icnt and ocnt, clear rd_addr, wr_addr, out_cnt, ovf and tmo. Go to FREQ if a frequency is pending, else FEED. A start with icnt=0 is ignored.
- FREQ: one cycle. new_freq=1, freq holds the pending code, pending flag clears. → FEED.
- FEED: issue one read, advance rd_addr, wait GAP cycles, repeat. After the icnt-th read → DRAIN.
- DRAIN: exit to DONE once out_cnt >= ocnt (immediately if ocnt=0).
- DONE: done=1 for one cycle, busy=0. → IDLE.
- Each wr_en increments wr_addr mod 2^OADDR_W and increments out_cnt (saturates at 2^(OADDR_W+1)-1). A write at wr_addr=all-ones sets ovf.
- fir_valid in IDLE/DONE is ignored: wr_en=0.
- freq_ld latches freq_in into the pending register in any state. It is applied only at the next accepted start. freq_ld and start in the same cycle → the new value is used.
- abort → IDLE on the next edge. in_valid and new_freq drop, no done pulse, pointers hold, pending frequency is kept. abort wins over a simultaneous start.
- Reset values: state=IDLE, all outputs 0, freq=0, pending flag clear.

## Timing
- Start sampled at edge N → busy=1 after N. FREQ occupies N+1. The first rd_addr=0 is presented in the cycle after FEED entry.
- in_valid is high exactly one cycle after its rd_addr cycle (BRAM latency 1).
- GAP=0 → icnt reads in icnt consecutive cycles. Otherwise reads are spaced GAP+1 cycles apart.
- wr_en is combinational from fir_valid and state (same cycle as filter data). wr_addr updates on the following edge.
- Last in_valid → DRAIN already active, so an output arriving in the same cycle as the last in_valid is counted.

## Configuration
- QMFIR_RUN_TIMEOUT_EN defined:
  - A DRAIN cycle counter starts at DRAIN entry.
  - After DRAIN_TO cycles without out_cnt >= ocnt → tmo=1, go to DONE with the normal done pulse.
- QMFIR_RUN_TIMEOUT_EN undefined:
  - No counter. tmo is tied 0.
  - DRAIN waits indefinitely; only abort or reset exits.

## Test plan
- Reset mid-FEED (icnt=100, arst at word 40) → all outputs 0 asynchronously; a new start restarts from rd_addr=0.
- freq_ld with freq_in=7'h2A while idle, then start with icnt=4, GAP=0 → new_freq for 1 cycle with freq=7'h2A, then rd_addr 0..3 on consecutive cycles, in_valid 1 cycle later each.
- GAP=2, icnt=3, ocnt=3, filter returns 3 fir_valid → reads 3 cycles apart, wr_addr 0,1,2, done pulse, wr_addr ends at 3.
- ocnt=130, OADDR_W=7, 130 fir_valid → ovf=1 at the write to address 127, final wr_addr=2, done=1.
- abort asserted in DRAIN together with start → IDLE next cycle, no done, start ignored. The next start works normally.
- QMFIR_RUN_TIMEOUT_EN, DRAIN_TO=16, ocnt=5, only 2 outputs → done and tmo=1 exactly 16 cycles after DRAIN entry.
